// File: rtl/sys_bus_hs_pkg.sv
// Shared definitions for the handshake peripheral bus: FSM encoding, error
// read data and the default chip-select values of the CPU memory map.
package sys_bus_hs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } bus_state_e;

  localparam logic [31:0] ERR_RDATA = 32'h0000_0000;

  localparam logic [3:0] SEL_DMEM = 4'h1;
  localparam logic [3:0] SEL_GPIO = 4'h2;
  localparam logic [3:0] SEL_UART = 4'h3;
  localparam logic [3:0] SEL_PWM  = 4'h4;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sys_bus_hs_dec.sv
// Address chip-select decoder: compares the select field against every slave
// base; the lowest matching slave index wins.
module sys_bus_dec #(
  parameter int NUM_SLV = 4,
  parameter int SW      = 4,
  parameter int IW      = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1
) (
  input  logic [SW-1:0]         sel_field,
  input  logic [NUM_SLV*SW-1:0] slv_base,
  output logic                  hit,
  output logic [NUM_SLV-1:0]    sel,
  output logic [IW-1:0]         idx
);

  // Scanning downwards lets the lowest matching index overwrite higher ones.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    sel = '0;
    for (int k = NUM_SLV - 1; k >= 0; k--) begin
      if (slv_base[k*SW +: SW] == sel_field) begin
        hit = 1'b1;
        idx = IW'(k);
      end
    end
    for (int k = 0; k < NUM_SLV; k++) begin
      sel[k] = hit && (idx == IW'(k));
    end
  end

endmodule

// File: rtl/sys_bus_hs.sv
// Registered single-master, multi-slave bus with req/ready handshake, byte
// strobes, per-access timeout and error reporting for unmapped/stalled accesses.
module sys_bus_hs
  import sys_bus_hs_pkg::*;
#(
  parameter int NUM_SLV = 4,
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int SEL_HI  = 31,
  parameter int SEL_LO  = 28,
  parameter logic [NUM_SLV*(SEL_HI-SEL_LO+1)-1:0] SLV_BASE =
    {SEL_PWM, SEL_UART, SEL_GPIO, SEL_DMEM},
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m_req,
  input  logic                  m_wen,
  input  logic [AW-1:0]         m_addr,
  input  logic [DW-1:0]         m_wdata,
  input  logic [DW/8-1:0]       m_wstrb,
  output logic [DW-1:0]         m_rdata,
  output logic                  m_ready,
  output logic                  m_err,
  output logic [NUM_SLV-1:0]    s_req,
  output logic                  s_wen,
  output logic [AW-1:0]         s_addr,
  output logic [DW-1:0]         s_wdata,
  output logic [DW/8-1:0]       s_wstrb,
  input  logic [NUM_SLV*DW-1:0] s_rdata,
  input  logic [NUM_SLV-1:0]    s_ready,
  output logic [7:0]            err_cnt,
  output logic [AW-1:0]         err_addr
);

  localparam int SW = SEL_HI - SEL_LO + 1;
  localparam int IW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int CW = $clog2(TIMEOUT);

  bus_state_e         state, state_d;
  logic [NUM_SLV-1:0] s_req_d;
  logic [IW-1:0]      sel_idx, sel_idx_d;
  logic [CW-1:0]      cnt, cnt_d;
  logic               m_ready_d, m_err_d;
  logic [DW-1:0]      m_rdata_d;
  logic [7:0]         err_cnt_d;
  logic [AW-1:0]      err_addr_d;
  logic               load;

  logic               dec_hit;
  logic [NUM_SLV-1:0] dec_sel;
  logic [IW-1:0]      dec_idx;
  logic [DW-1:0]      rdata_slice;

  sys_bus_dec #(
    .NUM_SLV (NUM_SLV),
    .SW      (SW),
    .IW      (IW)
  ) u_dec (
    .sel_field (m_addr[SEL_HI:SEL_LO]),
    .slv_base  (SLV_BASE),
    .hit       (dec_hit),
    .sel       (dec_sel),
    .idx       (dec_idx)
  );

  assign rdata_slice = s_rdata[sel_idx*DW +: DW];

  // Next-state logic; every registered output is computed here so the
  // master-side response appears exactly in the RESP cycle.
  always_comb begin
    state_d    = state;
    s_req_d    = s_req;
    sel_idx_d  = sel_idx;
    cnt_d      = cnt;
    m_ready_d  = 1'b0;
    m_err_d    = 1'b0;
    m_rdata_d  = m_rdata;
    err_cnt_d  = err_cnt;
    err_addr_d = err_addr;
    load       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (m_req) begin
          if (dec_hit) begin
            load      = 1'b1;
            s_req_d   = dec_sel;
            sel_idx_d = dec_idx;
            cnt_d     = '0;
            state_d   = ST_ACCESS;
          end else begin
            m_ready_d  = 1'b1;
            m_err_d    = 1'b1;
            m_rdata_d  = DW'(ERR_RDATA);
            err_cnt_d  = sat_inc8(err_cnt);
            err_addr_d = m_addr;
            state_d    = ST_RESP;
          end
        end
      end
      ST_ACCESS: begin
        // A ready on the final timeout cycle still completes without error.
        if (s_ready[sel_idx]) begin
          s_req_d   = '0;
          m_ready_d = 1'b1;
          m_rdata_d = s_wen ? '0 : rdata_slice;
          state_d   = ST_RESP;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          s_req_d    = '0;
          m_ready_d  = 1'b1;
          m_err_d    = 1'b1;
          m_rdata_d  = DW'(ERR_RDATA);
          err_cnt_d  = sat_inc8(err_cnt);
          err_addr_d = s_addr;
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        s_req_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      s_req    <= '0;
      sel_idx  <= '0;
      cnt      <= '0;
      m_ready  <= 1'b0;
      m_err    <= 1'b0;
      m_rdata  <= '0;
      err_cnt  <= 8'd0;
      err_addr <= '0;
      s_wen    <= 1'b0;
      s_addr   <= '0;
      s_wdata  <= '0;
      s_wstrb  <= '0;
    end else begin
      state    <= state_d;
      s_req    <= s_req_d;
      sel_idx  <= sel_idx_d;
      cnt      <= cnt_d;
      m_ready  <= m_ready_d;
      m_err    <= m_err_d;
      m_rdata  <= m_rdata_d;
      err_cnt  <= err_cnt_d;
      err_addr <= err_addr_d;
      if (load) begin
        s_wen   <= m_wen;
        s_addr  <= m_addr;
        s_wdata <= m_wdata;
        s_wstrb <= m_wen ? m_wstrb : '0;
      end
    end
  end

endmodule

// File: tb/tb_sys_bus_hs.sv
// Self-checking bench for sys_bus_hs: table of single transactions plus
// hand-written timeout, reset-abort, back-to-back and saturation sequences.
`timescale 1ns/1ps
module tb_sys_bus_hs;

  localparam int NUM_SLV = 4;
  localparam int DW      = 32;
  localparam int AW      = 32;
  localparam int TIMEOUT = 16;
  localparam int NEVER   = -1;
  localparam int NVEC    = 9;

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          waits;
    logic [31:0] srd;
    logic [3:0]  exp_sreq;
    int          exp_lat;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [7:0]  exp_err_cnt;
    logic [31:0] exp_err_addr;
  } vec_t;

  logic                  clk;
  logic                  rst_n;
  logic                  m_req;
  logic                  m_wen;
  logic [AW-1:0]         m_addr;
  logic [DW-1:0]         m_wdata;
  logic [DW/8-1:0]       m_wstrb;
  logic [DW-1:0]         m_rdata;
  logic                  m_ready;
  logic                  m_err;
  logic [NUM_SLV-1:0]    s_req;
  logic                  s_wen;
  logic [AW-1:0]         s_addr;
  logic [DW-1:0]         s_wdata;
  logic [DW/8-1:0]       s_wstrb;
  logic [NUM_SLV*DW-1:0] s_rdata;
  logic [NUM_SLV-1:0]    s_ready;
  logic [7:0]            err_cnt;
  logic [AW-1:0]         err_addr;

  int   tests;
  int   failures;
  vec_t vecs[NVEC];

  sys_bus_hs #(
    .NUM_SLV (NUM_SLV),
    .DW      (DW),
    .AW      (AW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m_req    (m_req),
    .m_wen    (m_wen),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_wstrb  (m_wstrb),
    .m_rdata  (m_rdata),
    .m_ready  (m_ready),
    .m_err    (m_err),
    .s_req    (s_req),
    .s_wen    (s_wen),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_wstrb  (s_wstrb),
    .s_rdata  (s_rdata),
    .s_ready  (s_ready),
    .err_cnt  (err_cnt),
    .err_addr (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input int idx,
                             input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s[%0d]: got 0x%08h, expected 0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic checkResetState(input int idx);
    checkOutput("rst_m_ready", idx, {31'd0, m_ready}, 32'd0);
    checkOutput("rst_m_err", idx, {31'd0, m_err}, 32'd0);
    checkOutput("rst_m_rdata", idx, m_rdata, 32'd0);
    checkOutput("rst_s_req", idx, {28'd0, s_req}, 32'd0);
    checkOutput("rst_s_bus", idx, {s_addr | s_wdata}, 32'd0);
    checkOutput("rst_s_ctl", idx, {27'd0, s_wen, s_wstrb}, 32'd0);
    checkOutput("rst_err_cnt", idx, {24'd0, err_cnt}, 32'd0);
    checkOutput("rst_err_addr", idx, err_addr, 32'd0);
  endtask

  // Runs one transaction with a behavioural slave; returns the completion
  // cycle (0 if it never completed) and counts protocol violations seen.
  task automatic applyStimulus(input vec_t v, output int lat, output logic [31:0] rd,
                               output logic er, output int viol);
    logic [3:0] exp_req;
    m_req   = 1'b1;
    m_wen   = v.wen;
    m_addr  = v.addr;
    m_wdata = v.wdata;
    m_wstrb = v.wstrb;
    s_ready = '0;
    for (int k = 0; k < NUM_SLV; k++)
      s_rdata[k*DW +: DW] = v.exp_sreq[k] ? v.srd : (32'hD0D0_0000 | k);
    lat  = 0;
    rd   = '0;
    er   = 1'b0;
    viol = 0;
    @(posedge clk); #1;
    for (int c = 1; c <= 40; c++) begin
      exp_req = (c < v.exp_lat) ? v.exp_sreq : 4'b0000;
      if (s_req !== exp_req) viol++;
      if (exp_req != 4'b0000) begin
        if (s_wen !== v.wen || s_addr !== v.addr ||
            s_wstrb !== (v.wen ? v.wstrb : 4'b0000) ||
            (v.wen && s_wdata !== v.wdata)) viol++;
      end
      if (m_ready === 1'b1) begin
        lat = c;
        rd  = m_rdata;
        er  = m_err;
        break;
      end
      if (m_err !== 1'b0) viol++;
      s_ready = '0;
      if (v.waits >= 0 && c == v.waits + 1) s_ready = v.exp_sreq;
      else if (v.exp_sreq != 4'b0000) s_ready = ~v.exp_sreq;
      @(posedge clk); #1;
    end
    m_req   = 1'b0;
    s_ready = '0;
  endtask

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        er;
    int          viol;
    int          mask;
    int          bad;
    vec_t        v;

    tests    = 0;
    failures = 0;
    rst_n    = 1'b0;
    m_req    = 1'b0;
    m_wen    = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;
    m_wstrb  = '0;
    s_rdata  = '0;
    s_ready  = '0;

    //          wen   addr          wdata         strb  waits  srd           sreq   lat rdata         err   ecnt  eaddr
    vecs[0] = '{1'b0, 32'h2000_0004, 32'h0,        4'hF, 0,     32'h0000_00A5, 4'b0010, 2,  32'h0000_00A5, 1'b0, 8'd0, 32'h0};
    vecs[1] = '{1'b0, 32'h7000_0000, 32'h0,        4'hF, 0,     32'h0,         4'b0000, 1,  32'h0,         1'b1, 8'd1, 32'h7000_0000};
    vecs[2] = '{1'b1, 32'h3000_0000, 32'h55,       4'h1, 3,     32'hBEEF_0000, 4'b0100, 5,  32'h0,         1'b0, 8'd1, 32'h7000_0000};
    vecs[3] = '{1'b0, 32'h1000_0010, 32'h0,        4'h0, 1,     32'h1234_5678, 4'b0001, 3,  32'h1234_5678, 1'b0, 8'd1, 32'h7000_0000};
    vecs[4] = '{1'b0, 32'h4000_0000, 32'h0,        4'hF, 2,     32'hCAFE_F00D, 4'b1000, 4,  32'hCAFE_F00D, 1'b0, 8'd1, 32'h7000_0000};
    vecs[5] = '{1'b1, 32'h1000_0000, 32'hA5A5_A5A5, 4'hF, 0,    32'hFFFF_FFFF, 4'b0001, 2,  32'h0,         1'b0, 8'd1, 32'h7000_0000};
    vecs[6] = '{1'b0, 32'h1000_0020, 32'h0,        4'h0, 15,    32'h600D_F00D, 4'b0001, 17, 32'h600D_F00D, 1'b0, 8'd1, 32'h7000_0000};
    vecs[7] = '{1'b0, 32'h0000_0000, 32'h0,        4'h0, 0,     32'h0,         4'b0000, 1,  32'h0,         1'b1, 8'd2, 32'h0};
    vecs[8] = '{1'b0, 32'h1000_0040, 32'h0,        4'h0, NEVER, 32'h0BAD_0BAD, 4'b0001, 17, 32'h0,         1'b1, 8'd3, 32'h1000_0040};

    repeat (2) @(posedge clk);
    #1;
    checkResetState(0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i], lat, rd, er, viol);
      checkOutput("latency", i, lat, vecs[i].exp_lat);
      checkOutput("m_rdata", i, rd, vecs[i].exp_rdata);
      checkOutput("m_err", i, {31'd0, er}, {31'd0, vecs[i].exp_err});
      checkOutput("slave_side", i, viol, 0);
      @(posedge clk); #1;
      checkOutput("err_cnt", i, {24'd0, err_cnt}, {24'd0, vecs[i].exp_err_cnt});
      checkOutput("err_addr", i, err_addr, vecs[i].exp_err_addr);
    end

    // Stray ready from DMEM after the timeout response must do nothing.
    s_ready = 4'b0001;
    @(posedge clk); #1;
    s_ready = '0;
    checkOutput("stray_m_ready", 0, {31'd0, m_ready}, 32'd0);
    checkOutput("stray_s_req", 0, {28'd0, s_req}, 32'd0);
    @(posedge clk); #1;
    checkOutput("stray_m_ready", 1, {31'd0, m_ready}, 32'd0);
    checkOutput("stray_err_cnt", 0, {24'd0, err_cnt}, 32'd3);

    // Reset during ACCESS cycle 2 aborts the transfer; a late ready is ignored.
    m_req  = 1'b1;
    m_wen  = 1'b0;
    m_addr = 32'h1000_0008;
    @(posedge clk); #1;
    m_req = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort_s_req", 0, {28'd0, s_req}, 32'd1);
    rst_n   = 1'b0;
    s_ready = 4'b0001;
    @(posedge clk); #1;
    checkResetState(1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    s_ready = '0;
    checkOutput("abort_m_ready", 0, {31'd0, m_ready}, 32'd0);
    @(posedge clk); #1;
    checkOutput("abort_m_ready", 1, {31'd0, m_ready}, 32'd0);
    v = '{1'b0, 32'h2000_0008, 32'h0, 4'h0, 0, 32'h0000_005A, 4'b0010, 2,
          32'h0000_005A, 1'b0, 8'd0, 32'h0};
    applyStimulus(v, lat, rd, er, viol);
    checkOutput("post_rst_lat", 0, lat, 2);
    checkOutput("post_rst_rdata", 0, rd, 32'h0000_005A);
    checkOutput("post_rst_err", 0, {31'd0, er}, 32'd0);
    checkOutput("post_rst_side", 0, viol, 0);
    @(posedge clk); #1;

    // Back-to-back: m_req held high, DMEM then GPIO, both zero-wait.
    m_req   = 1'b1;
    m_wen   = 1'b0;
    m_addr  = 32'h1000_0000;
    s_rdata = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    mask    = 0;
    bad     = 0;
    @(posedge clk); #1;
    for (int c = 1; c <= 7; c++) begin
      s_ready = '0;
      if (m_ready === 1'b1) begin
        mask = mask | (1 << c);
        if (c == 2 && m_rdata !== 32'h1111_1111) bad++;
        if (c == 5 && m_rdata !== 32'h2222_2222) bad++;
        if (c == 2) m_addr = 32'h2000_0000;
        if (c == 5) m_req = 1'b0;
      end
      if (c == 1 && s_req === 4'b0001) s_ready = 4'b0001;
      if (c == 4 && s_req === 4'b0010) s_ready = 4'b0010;
      @(posedge clk); #1;
    end
    s_ready = '0;
    checkOutput("b2b_ready_cycles", 0, mask, (1 << 2) | (1 << 5));
    checkOutput("b2b_rdata", 0, bad, 0);

    // 260 unmapped accesses saturate the error counter at 255.
    bad = 0;
    for (int i = 0; i < 260; i++) begin
      v = '{1'b0, 32'hF000_0000 | i, 32'h0, 4'h0, 0, 32'h0, 4'b0000, 1,
            32'h0, 1'b1, 8'd0, 32'h0};
      applyStimulus(v, lat, rd, er, viol);
      if (lat != 1 || er !== 1'b1 || viol != 0) bad++;
      @(posedge clk); #1;
    end
    checkOutput("sat_txns", 0, bad, 0);
    checkOutput("sat_err_cnt", 0, {24'd0, err_cnt}, 32'd255);
    checkOutput("sat_err_addr", 0, err_addr, 32'hF000_0103);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
